scaler_line_sched: RTL
======================

SCALER_LINE_SCHED -- requirements
Module: scaler_line_sched

Interface
REQ-001 SHALL have parameter SRC_IMAGE_RES_WIDTH, default 640, source pixels per line.
REQ-002 SHALL have parameter SRC_IMAGE_RES_HEIGHT, default 720, source lines per frame.
REQ-003 SHALL have port pixclk_in  input  1  pixel clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port vs_in  input  1  frame-start pulse, one cycle.
REQ-006 SHALL have port de_in  input  1  source data enable; one high run per line.
REQ-007 SHALL have port rd_done  input  1  one-cycle pulse from second-pass reader: page fully consumed.
REQ-008 SHALL have port wr_ram_sel  output  1  line-buffer RAM for the current source line (0 = ram0, 1 = ram1).
REQ-009 SHALL have port wr_page  output  1  page (address MSB) for the current source line.
REQ-010 SHALL have port rd_start  output  1  one-cycle pulse: start second pass on rd_page.
REQ-011 SHALL have port rd_page  output  1  page to read; valid from rd_start until rd_done.
REQ-012 SHALL have port rd_busy  output  1  reader owns rd_page.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse: all page pairs of the frame consumed.
REQ-014 SHALL have port overrun  output  1  sticky: page pair completed while still pending or being read.
REQ-015 SHALL have port line_err  output  1  sticky: line length mismatch (see Configuration).

Function
REQ-016 SHALL run FSM states IDLE, ACTIVE, FLUSH; reset state IDLE.
REQ-017 SHALL move IDLE->ACTIVE on vs_in and clear src_line, pending bits, rd pointer, overrun, line_err.
REQ-018 SHALL register de_in to de_d; line end = de_d & !de_in (cycle N).
REQ-019 SHALL increment src_line (10-bit) at cycle N+1; wr_ram_sel = src_line[0], wr_page = src_line[1] combinational from the register.
REQ-020 SHALL, at line end with src_line[0]=1, set pend[src_line[1]] at N+1; if pend already set or (rd_busy and rd_page equal), set overrun at N+1.
REQ-021 SHALL, when rd_busy=0 and pend[rd_ptr]=1, assert rd_start for one cycle, set rd_page=rd_ptr, rd_busy=1, clear pend[rd_ptr], toggle rd_ptr; start occurs in the same cycle pend becomes visible +1 (rd_start at N+2 when idle).
REQ-022 SHALL clear rd_busy on rd_done; rd_done while rd_busy=0 is ignored.
REQ-023 SHALL allow rd_done and a new start in consecutive cycles, never the same cycle.
REQ-024 SHALL move ACTIVE->FLUSH when src_line reaches SRC_IMAGE_RES_HEIGHT; de_in ignored in FLUSH.
REQ-025 SHALL, in FLUSH, pulse frame_done and go IDLE the cycle after pend=0 and rd_busy=0.
REQ-026 SHALL treat vs_in in ACTIVE or FLUSH as restart: drop pend, rd_busy, counters; re-enter ACTIVE; no frame_done.
REQ-027 SHALL keep overrun and line_err until next vs_in or reset.

Reset
REQ-028 SHALL on rst_n=0 set state IDLE, src_line 0, pend 0, rd_ptr 0, de_d 0.
REQ-029 SHALL on reset drive wr_ram_sel 0, wr_page 0, rd_start 0, rd_page 0, rd_busy 0, frame_done 0, overrun 0, line_err 0.
REQ-030 SHALL let reset override vs_in, de_in and rd_done in the same cycle.

Configuration
REQ-031 SHALL honour macro SCALER_LINE_CHECK_EN.
REQ-032 SHALL, with SCALER_LINE_CHECK_EN defined, count de_in cycles per line and set line_err at N+1 if count != SRC_IMAGE_RES_WIDTH.
REQ-033 SHALL, without it, omit the pixel counter and tie line_err to 0.

Verification (SRC_IMAGE_RES_WIDTH=8, SRC_IMAGE_RES_HEIGHT=8)
REQ-034 SHALL test reset: rst_n=0 for 3 cycles with vs_in, de_in toggling -> all outputs 0, state IDLE.
REQ-035 SHALL test nominal frame: vs_in, 8 lines of 8 pixels, rd_done 20 cycles after each rd_start -> wr_ram_sel 0,1,0,1..., wr_page 0,0,1,1,0,0,1,1; 4 rd_start pulses with rd_page 0,1,0,1; one frame_done; overrun=0.
REQ-036 SHALL test overrun: rd_done withheld after first rd_start -> overrun=1 at end of line 6 (page 0 pair rewritten), remains 1 until next vs_in.
REQ-037 SHALL test back-to-back: both pages pending, rd_done pulsed -> next rd_start exactly 1 cycle later on the other page.
REQ-038 SHALL test line check: line of 7 pixels -> line_err=1 with SCALER_LINE_CHECK_EN; line_err=0 without.
REQ-039 SHALL test mid-frame vs_in after line 3 -> pend, rd_busy cleared, src_line 0, no frame_done, next frame completes normally.

Source files
------------

// File: rtl/scaler_line_sched.sv
// -----------------------------------------------------------------------------
// scaler_line_sched
//
// Line scheduler for a two-pass scaler. It steers each incoming source line
// into one of two line-buffer RAMs (ram0/ram1), each split into two pages. A
// pair of lines (ram0 + ram1, same page) forms one unit of work for the
// second-pass reader. When a pair is complete its page is marked pending. The
// reader is then started on the pending pages in alternating page order.
//
// Ports
//   pixclk_in   in   pixel clock, all logic on the rising edge
//   rst_n       in   synchronous, active-low reset
//   vs_in       in   frame-start pulse; also restarts a frame in progress
//   de_in       in   source data enable, one high run per line
//   rd_done     in   reader finished consuming rd_page
//   wr_ram_sel  out  RAM receiving the current source line (0 = ram0)
//   wr_page     out  page (address MSB) for the current source line
//   rd_start    out  one-cycle pulse: reader may start on rd_page
//   rd_page     out  page to read, held from rd_start until rd_done
//   rd_busy     out  reader currently owns rd_page
//   frame_done  out  one-cycle pulse: every page pair of the frame consumed
//   overrun     out  sticky: a pair completed on a page still pending/read
//   line_err    out  sticky: source line length differs from the width
//
// Build option
//   SCALER_LINE_CHECK_EN  when defined, count pixels per line and flag
//                         length mismatches on line_err; otherwise line_err
//                         is tied low and the counter is absent.
// -----------------------------------------------------------------------------
module scaler_line_sched #(
    parameter int SRC_IMAGE_RES_WIDTH  = 640,
    parameter int SRC_IMAGE_RES_HEIGHT = 720
) (
    input  logic pixclk_in,
    input  logic rst_n,
    input  logic vs_in,
    input  logic de_in,
    input  logic rd_done,
    output logic wr_ram_sel,
    output logic wr_page,
    output logic rd_start,
    output logic rd_page,
    output logic rd_busy,
    output logic frame_done,
    output logic overrun,
    output logic line_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         frame_done_nxt;

    logic         de_d;
    logic [9:0]   src_line;
    logic [1:0]   pend;
    logic         rd_ptr;

    logic         line_end;
    logic         rd_free;
    logic         start_go;
    logic         pair_page;

    // Falling edge of de_in, only meaningful while lines are being accepted.
    assign line_end  = (state == ACTIVE) && de_d && !de_in;

    // The reader is free if idle, or if it signals completion this cycle; the
    // latter lets a queued page start on the very next cycle after rd_done.
    assign rd_free   = !rd_busy || rd_done;
    assign start_go  = rd_free && pend[rd_ptr];

    assign pair_page = src_line[1];

    assign wr_ram_sel = src_line[0];
    assign wr_page    = src_line[1];

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge pixclk_in) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and frame_done decision
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first, so no path through the block leaves a
        // variable unassigned and no latch is inferred.
        state_nxt      = state;
        frame_done_nxt = 1'b0;

        if (vs_in) begin
            // Frame start, or restart of a frame in progress.
            state_nxt = ACTIVE;
        end else begin
            unique case (state)
                IDLE: ;
                ACTIVE: begin
                    // Last source line ends: src_line becomes the height
                    // on the same edge the FSM enters FLUSH.
                    if (line_end &&
                        (src_line == 10'(SRC_IMAGE_RES_HEIGHT - 1))) begin
                        state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if ((pend == 2'b00) && !rd_busy) begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Line counting, pair bookkeeping and reader hand-off
    // -------------------------------------------------------------------------
    always_ff @(posedge pixclk_in) begin
        if (!rst_n) begin
            de_d       <= 1'b0;
            src_line   <= '0;
            pend       <= 2'b00;
            rd_ptr     <= 1'b0;
            rd_start   <= 1'b0;
            rd_page    <= 1'b0;
            rd_busy    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            de_d       <= de_in;
            rd_start   <= 1'b0;
            frame_done <= frame_done_nxt;

            if (vs_in) begin
                src_line <= '0;
                pend     <= 2'b00;
                rd_ptr   <= 1'b0;
                rd_busy  <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (rd_done) begin
                    rd_busy <= 1'b0;
                end

                if (start_go) begin
                    rd_start     <= 1'b1;
                    rd_page      <= rd_ptr;
                    rd_busy      <= 1'b1;
                    pend[rd_ptr] <= 1'b0;
                    rd_ptr       <= ~rd_ptr;
                end

                if (line_end) begin
                    src_line <= src_line + 10'd1;
                    // An odd line closes a ram0/ram1 pair on its page.
                    // Placed after the start hand-off so a re-completed
                    // page stays pending even if it is being started now.
                    if (src_line[0]) begin
                        pend[pair_page] <= 1'b1;
                        if (pend[pair_page] ||
                            (rd_busy && (rd_page == pair_page))) begin
                            overrun <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional line-length check
    // -------------------------------------------------------------------------
`ifdef SCALER_LINE_CHECK_EN
    // Wide enough that the saturated value can never equal the width.
    localparam int PIX_W = $clog2(SRC_IMAGE_RES_WIDTH + 2);

    logic [PIX_W-1:0] pix_cnt;

    always_ff @(posedge pixclk_in) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_err <= 1'b0;
        end else if (vs_in) begin
            pix_cnt  <= '0;
            line_err <= 1'b0;
        end else if (state == ACTIVE) begin
            if (line_end) begin
                if (pix_cnt != PIX_W'(SRC_IMAGE_RES_WIDTH)) begin
                    line_err <= 1'b1;
                end
                pix_cnt <= '0;
            end else if (de_in && (pix_cnt != '1)) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end
`else
    assign line_err = 1'b0;
`endif

endmodule
